rom_sequencer: RTL and testbench

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/rom_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_rom_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// ROM address sequencer. It steps through [ADDR_FIRST, ADDR_LAST] on a timed or manual advance
// and registers each fetched ROM word, with a one-cycle valid pulse per word.
module rom_sequencer #(
  parameter int TICK_MAX   = 24_999_999,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 4,
  parameter int ADDR_FIRST = 0,
  parameter int ADDR_LAST  = 31,
  parameter int ROM_LAT    = 1,
  parameter int OUT_INV    = 1
) (
  input  logic              sclk,
  input  logic              nrst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              step,
  input  logic              clr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] n_data,
  output logic              data_vld,
  output logic              done
);

  localparam int                TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_MAX);
  localparam logic [ADDR_W-1:0] A_FIRST  = ADDR_W'(ADDR_FIRST);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(ADDR_LAST);
  localparam logic [DATA_W-1:0] DATA_RST = (OUT_INV != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_SHOT = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [TICK_W-1:0]  r_tick;
  logic [ADDR_W-1:0]  r_addr;
  dir_e               r_dir;
  logic               r_done;
  logic               r_init;
  logic [ROM_LAT-1:0] r_pipe;
  logic [DATA_W-1:0]  r_data;
  logic               r_vld;

  mode_e              w_mode;
  logic               w_adv;
  logic               w_take;
  logic               w_load;
  logic               w_exit;
  logic [TICK_W-1:0]  w_tick_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [ADDR_W-1:0]  w_inc;
  logic [ADDR_W-1:0]  w_dec;
  dir_e               w_dir_nxt;
  logic               w_done_nxt;
  logic [DATA_W-1:0]  w_word;

  assign w_mode = mode_e'(mode);
  assign w_adv  = en ? (r_tick == TICK_TOP) : step;
  assign w_inc  = r_addr + ADDR_W'(1);
  assign w_dec  = r_addr - ADDR_W'(1);
  // A reload token enters on reset release, on clr and on every accepted advance.
  assign w_load = r_init | clr | w_take;
  assign w_exit = r_pipe[ROM_LAT-1];
  assign w_word = (OUT_INV != 0) ? ~rom_q : rom_q;

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    w_tick_nxt = r_tick;
    if (clr) begin
      w_tick_nxt = {TICK_W{1'b0}};
    end else if (!en) begin
      w_tick_nxt = {TICK_W{1'b0}};
    end else if (r_tick == TICK_TOP) begin
      w_tick_nxt = {TICK_W{1'b0}};
    end else begin
      w_tick_nxt = r_tick + TICK_W'(1);
    end
  end

  // Address, direction and done update for each advance mode.
  always_comb begin
    w_addr_nxt = r_addr;
    w_dir_nxt  = r_dir;
    w_done_nxt = r_done;
    w_take     = 1'b0;
    if (clr) begin
      w_addr_nxt = A_FIRST;
      w_dir_nxt  = DIR_UP;
      w_done_nxt = 1'b0;
    end else if (w_adv) begin
      w_take = 1'b1;
      case (w_mode)
        MODE_UP: begin
          w_done_nxt = 1'b0;
          w_addr_nxt = (r_addr == A_LAST) ? A_FIRST : w_inc;
        end
        MODE_DOWN: begin
          w_done_nxt = 1'b0;
          w_addr_nxt = (r_addr == A_FIRST) ? A_LAST : w_dec;
        end
        MODE_PING: begin
          w_done_nxt = 1'b0;
          // Direction flips when leaving a bound, so a mode entry at a bound still turns around.
          if (r_dir == DIR_UP) begin
            if (r_addr == A_LAST) begin
              w_addr_nxt = w_dec;
              w_dir_nxt  = DIR_DOWN;
            end else begin
              w_addr_nxt = w_inc;
            end
          end else begin
            if (r_addr == A_FIRST) begin
              w_addr_nxt = w_inc;
              w_dir_nxt  = DIR_UP;
            end else begin
              w_addr_nxt = w_dec;
            end
          end
        end
        MODE_SHOT: begin
          if (r_done) begin
            w_take = 1'b0;
          end else if (r_addr == A_LAST) begin
            w_done_nxt = 1'b1;
          end else begin
            w_addr_nxt = w_inc;
            w_done_nxt = (w_inc == A_LAST);
          end
        end
        default: begin
          w_addr_nxt = r_addr;
        end
      endcase
      if (A_FIRST == A_LAST) begin
        w_addr_nxt = A_FIRST;
      end else begin
        w_addr_nxt = w_addr_nxt;
      end
    end else begin
      w_take = 1'b0;
    end
  end

  // State, load pipeline and output word registers.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      r_tick <= {TICK_W{1'b0}};
      r_addr <= A_FIRST;
      r_dir  <= DIR_UP;
      r_done <= 1'b0;
      r_init <= 1'b1;
      r_pipe <= {ROM_LAT{1'b0}};
      r_data <= DATA_RST;
      r_vld  <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
      r_addr <= w_addr_nxt;
      r_dir  <= w_dir_nxt;
      r_done <= w_done_nxt;
      r_init <= 1'b0;
      r_pipe <= (r_pipe << 1) | ROM_LAT'(w_load);
      r_vld  <= w_exit;
      if (w_exit) begin
        r_data <= w_word;
      end
    end
  end

  assign rom_addr = r_addr;
  assign n_data   = r_data;
  assign data_vld = r_vld;
  assign done     = r_done;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: directed table, corner-case sequences and a random run,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_rom_sequencer;

  localparam int TMAX = 3;
  localparam int AW   = 5;
  localparam int DW   = 4;
  localparam int AF   = 2;
  localparam int AL   = 5;
  localparam int LAT  = 1;

  logic          sclk = 1'b0;
  logic          nrst = 1'b0;
  logic          en   = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          step = 1'b0;
  logic          clr  = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] n_data;
  logic          data_vld;
  logic          done;
  logic [AW-1:0] rom_sum;

  assign rom_sum = rom_addr + 5'd8;
  assign rom_q   = rom_sum[DW-1:0];

  always #5 sclk = ~sclk;

  rom_sequencer #(
    .TICK_MAX(TMAX), .ADDR_W(AW), .DATA_W(DW), .ADDR_FIRST(AF),
    .ADDR_LAST(AL), .ROM_LAT(LAT), .OUT_INV(1)
  ) dut (
    .sclk(sclk), .nrst(nrst), .en(en), .mode(mode), .step(step), .clr(clr),
    .rom_addr(rom_addr), .rom_q(rom_q), .n_data(n_data), .data_vld(data_vld), .done(done)
  );

  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic       step;
    logic       clr;
    logic [4:0] addr;
    logic       vld;
    logic [3:0] nd;
    logic       done;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] val;
  } ev_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         m_addr, m_dir, m_tick, m_cyc;
  bit         m_done, m_init;
  logic [3:0] m_nd;
  ev_t        m_q[$];
  vec_t       tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] word(input int a);
    logic [4:0] s;
    s = 5'(a + 8);
    return ~s[3:0];
  endfunction

  function automatic vec_t mkv(input logic [4:0] a, input logic v, input logic [3:0] nd);
    vec_t r;
    r.en = 1'b1; r.mode = 2'd0; r.step = 1'b0; r.clr = 1'b0;
    r.addr = a; r.vld = v; r.nd = nd; r.done = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_addr = AF; m_dir = 1; m_tick = 0; m_done = 0; m_init = 1; m_nd = 4'hF;
    m_q.delete();
  endtask

  // Behavioural model of one clock edge, using the inputs held during the cycle.
  task automatic model_edge();
    bit adv, load;
    int n;
    m_cyc++;
    load = 0;
    adv  = 0;
    if (clr) begin
      m_addr = AF; m_tick = 0; m_dir = 1; m_done = 0; load = 1;
    end else begin
      if (en) begin
        adv = (m_tick == TMAX);
        m_tick = adv ? 0 : m_tick + 1;
      end else begin
        adv = step;
        m_tick = 0;
      end
      if (adv) begin
        case (mode)
          2'd0: begin m_addr = (m_addr == AL) ? AF : m_addr + 1; m_done = 0; load = 1; end
          2'd1: begin m_addr = (m_addr == AF) ? AL : m_addr - 1; m_done = 0; load = 1; end
          2'd2: begin
            n = m_addr + m_dir;
            if (n > AL || n < AF) begin
              m_dir = -m_dir;
              n = m_addr + m_dir;
            end
            m_addr = n; m_done = 0; load = 1;
          end
          default: begin
            if (!m_done) begin
              if (m_addr < AL) m_addr++;
              m_done = (m_addr == AL);
              load = 1;
            end
          end
        endcase
      end
    end
    if (m_init) begin
      load = 1;
      m_init = 0;
    end
    if (load) m_q.push_back('{m_cyc + LAT, word(m_addr)});
  endtask

  task automatic cycle_chk();
    bit   e_vld;
    ev_t  ev;
    @(posedge sclk);
    if (nrst) model_edge();
    @(negedge sclk);
    e_vld = 0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc && nrst) begin
      e_vld = 1;
      ev = m_q.pop_front();
      m_nd = ev.val;
    end
    chk("model_addr", 32'(rom_addr), m_addr);
    chk("model_vld", 32'(data_vld), 32'(e_vld));
    chk("model_ndata", 32'(n_data), 32'(m_nd));
    chk("model_done", 32'(done), 32'(m_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pp_exp[8];
    int   got[$];
    int   prev;
    bit   found;

    tbl[0]  = mkv(5'd2, 1'b0, 4'hF); tbl[1]  = mkv(5'd2, 1'b1, 4'h5);
    tbl[2]  = mkv(5'd2, 1'b0, 4'h5); tbl[3]  = mkv(5'd3, 1'b0, 4'h5);
    tbl[4]  = mkv(5'd3, 1'b1, 4'h4); tbl[5]  = mkv(5'd3, 1'b0, 4'h4);
    tbl[6]  = mkv(5'd3, 1'b0, 4'h4); tbl[7]  = mkv(5'd4, 1'b0, 4'h4);
    tbl[8]  = mkv(5'd4, 1'b1, 4'h3); tbl[9]  = mkv(5'd4, 1'b0, 4'h3);
    tbl[10] = mkv(5'd4, 1'b0, 4'h3); tbl[11] = mkv(5'd5, 1'b0, 4'h3);
    tbl[12] = mkv(5'd5, 1'b1, 4'h2); tbl[13] = mkv(5'd5, 1'b0, 4'h2);
    tbl[14] = mkv(5'd5, 1'b0, 4'h2); tbl[15] = mkv(5'd2, 1'b0, 4'h2);
    tbl[16] = mkv(5'd2, 1'b1, 4'h5); tbl[17] = mkv(5'd2, 1'b0, 4'h5);
    pp_exp = '{2, 3, 4, 5, 4, 3, 2, 3};
    m_cyc = 0;
    model_reset();

    // Reset state and up-wrap timing from reset release.
    en = 1'b1; mode = 2'd0;
    repeat (3) cycle_chk();
    nrst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; step = tbl[i].step; clr = tbl[i].clr;
      cycle_chk();
      chk("tbl_addr", 32'(rom_addr), 32'(tbl[i].addr));
      chk("tbl_vld", 32'(data_vld), 32'(tbl[i].vld));
      chk("tbl_ndata", 32'(n_data), 32'(tbl[i].nd));
      chk("tbl_done", 32'(done), 32'(tbl[i].done));
    end

    // clr coincident with an advance at address 4.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_addr == 4 && m_tick == TMAX) found = 1;
      else cycle_chk();
    end
    chk("reach_clr_point", 32'(found), 32'd1);
    clr = 1'b1;
    cycle_chk();
    clr = 1'b0;
    chk("clr_addr", 32'(rom_addr), 32'd2);
    cycle_chk();
    chk("clr_vld", 32'(data_vld), 32'd1);
    chk("clr_ndata", 32'(n_data), 32'h5);
    cycle_chk();
    chk("clr_single_vld", 32'(data_vld), 32'd0);
    cycle_chk();
    chk("clr_hold_addr", 32'(rom_addr), 32'd2);
    cycle_chk();
    chk("clr_tick_zero", 32'(rom_addr), 32'd3);

    // Ping-pong traversal.
    clr = 1'b1; mode = 2'd2;
    cycle_chk();
    clr = 1'b0;
    got.push_back(int'(rom_addr));
    prev = int'(rom_addr);
    for (int i = 0; i < 60 && got.size() < 8; i++) begin
      cycle_chk();
      if (int'(rom_addr) != prev) begin
        prev = int'(rom_addr);
        got.push_back(prev);
      end
    end
    for (int i = 0; i < 8; i++) chk("pp_seq", (got.size() > i) ? got[i] : -1, pp_exp[i]);

    // Single-shot park and exit.
    clr = 1'b1; mode = 2'd3;
    cycle_chk();
    clr = 1'b0;
    for (int i = 0; i < 40 && done !== 1'b1; i++) cycle_chk();
    chk("ss_done_rise", 32'(done), 32'd1);
    chk("ss_addr_last", 32'(rom_addr), 32'd5);
    repeat (20) cycle_chk();
    chk("ss_hold_addr", 32'(rom_addr), 32'd5);
    chk("ss_hold_done", 32'(done), 32'd1);
    mode = 2'd0;
    for (int i = 0; i < 10 && rom_addr == 5'd5; i++) cycle_chk();
    chk("ss_exit_addr", 32'(rom_addr), 32'd2);
    chk("ss_exit_done", 32'(done), 32'd0);

    // Manual back-to-back steps in down-wrap.
    en = 1'b0; mode = 2'd1; clr = 1'b1;
    cycle_chk();
    clr = 1'b0;
    cycle_chk();
    step = 1'b1;
    cycle_chk(); chk("step_addr0", 32'(rom_addr), 32'd5);
    cycle_chk(); chk("step_addr1", 32'(rom_addr), 32'd4); chk("step_vld0", 32'(n_data), 32'h2);
    cycle_chk(); chk("step_addr2", 32'(rom_addr), 32'd3); chk("step_vld1", 32'(n_data), 32'h3);
    step = 1'b0;
    cycle_chk(); chk("step_vld2", 32'(data_vld), 32'd1); chk("step_nd2", 32'(n_data), 32'h4);
    cycle_chk(); chk("step_vld_end", 32'(data_vld), 32'd0);

    // Asynchronous reset mid-period at address 4.
    en = 1'b1; mode = 2'd0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle_chk();
      if (m_addr == 4 && m_tick == 1) found = 1;
    end
    chk("reach_rst_point", 32'(found), 32'd1);
    nrst = 1'b0;
    model_reset();
    #1;
    chk("rst_ndata", 32'(n_data), 32'hF);
    chk("rst_vld", 32'(data_vld), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd2);
    repeat (2) cycle_chk();
    nrst = 1'b1;
    cycle_chk();
    cycle_chk();
    chk("rst_rel_vld", 32'(data_vld), 32'd1);
    chk("rst_rel_ndata", 32'(n_data), 32'h5);

    // Randomised run against the model.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      step = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      cycle_chk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
